// File: rtl/seq_squarer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_squarer : iterative shift-add unsigned squarer, one multiplier bit/clock
// Revision    : 1.0
// ----------------------------------------------------------------------------
module seq_squarer #(
  parameter int WIDTH = 11,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;
  logic               last_iter;

  assign addend    = mplier[0] ? mcand : '0;
  assign sum       = acc + addend;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = start ? S_CALC : S_IDLE;
      S_CALC:  next_state = last_iter ? S_DONE : S_CALC;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC);
    done = (state == S_DONE);
  end

  // The final iteration's sum goes straight to result so DONE follows the WIDTH-th edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, operand};
            mplier <= operand;
            count  <= '0;
          end
        end
        S_CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (last_iter) begin
            result <= sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_squarer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_squarer : directed and exhaustive checks for seq_squarer
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_seq_squarer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] operand;
  logic        busy;
  logic        done;
  logic [21:0] result;

  int checks;
  int failures;
  logic [21:0] last_res;

  seq_squarer #(.WIDTH(11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and verify latency, busy span, result, pulse width and hold.
  task automatic do_op(input logic [10:0] a, input logic [21:0] exp, input string tag);
    int n;
    int bc;
    logic stable;
    @(negedge clk);
    start   = 1'b1;
    operand = a;
    @(negedge clk);
    start   = 1'b0;
    operand = ~a;
    n = 0;
    bc = 0;
    stable = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      if (result !== last_res) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd11);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd11);
    check({tag, "_hold_during_calc"}, 64'(stable), 64'd1);
    check({tag, "_done_busy_excl"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_result_held"}, 64'(result), 64'(exp));
    last_res = exp;
  endtask

  initial begin
    int n;
    int dcount;
    checks   = 0;
    failures = 0;
    last_res = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    operand  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_done", 64'(done), 64'd0);

    do_op(11'd0,    22'h000000, "zero");
    do_op(11'd2047, 22'h3FF001, "max");
    do_op(11'd1024, 22'h100000, "pow2");

    // Start pulsed again mid-CALC must be ignored.
    @(negedge clk);
    start = 1'b1; operand = 11'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; operand = 11'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("midcalc_latency", 64'(n), 64'd6);
    check("midcalc_result", 64'(result), 64'd9);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("midcalc_no_second_done", 64'(dcount), 64'd0);
    check("midcalc_result_held", 64'(result), 64'd9);

    // Start held high: back-to-back operations 13 cycles apart.
    start = 1'b1; operand = 11'd7;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held_first_result", 64'(result), 64'd49);
    operand = 11'd9;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held_spacing", 64'(n), 64'd13);
    check("held_second_result", 64'(result), 64'd81);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during CALC iteration 5.
    start = 1'b1; operand = 11'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    do_op(11'd100, 22'd10000, "after_reset");

    for (int a = 0; a < 2048; a++) begin
      do_op(11'(a), 22'(a) * 22'(a), "exh");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
